// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider with start/busy/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DZERO,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] d_r;

  logic [WIDTH:0]   p;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;

  assign p     = {r_r, q_r[WIDTH-1]};
  assign t     = p - {1'b0, d_r};
  assign q_nxt = {q_r[WIDTH-2:0], ~t[WIDTH]};
  assign r_nxt = t[WIDTH] ? p[WIDTH-1:0] : t[WIDTH-1:0];

`ifdef SIGNED_DIV_EN
  logic neg_q;
  logic neg_r;

  // A zero divisor keeps the raw dividend in Q so DZERO can return it as-is.
  assign a_cap = (dividend[WIDTH-1] && divisor != '0)
               ? -dividend : dividend;
  assign b_cap = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_fin = neg_q ? -q_nxt : q_nxt;
  assign r_fin = neg_r ? -r_nxt : r_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign a_cap = dividend;
  assign b_cap = divisor;
  assign q_fin = q_nxt;
  assign r_fin = r_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      q_r         <= '0;
      r_r         <= '0;
      d_r         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q_r         <= a_cap;
            r_r         <= '0;
            d_r         <= b_cap;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= (divisor == '0) ? DZERO : CALC;
          end
        end
        CALC: begin
          q_r <= q_nxt;
          r_r <= r_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            quotient  <= q_fin;
            remainder <= r_fin;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DZERO: begin
          quotient    <= '1;
          remainder   <= q_r;
          div_by_zero <= 1'b1;
          busy        <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
